// File: rtl/mcu_fsm.sv
// mcu_fsm: multi-cycle MIPS main controller.
// A Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and
// drives the datapath selects and write enables. It also handshakes with a
// variable-latency memory (req/ack) and counts retired instructions.
// Optional feature: define MCU_FSM_TRAP_EN to trap illegal opcodes. When it
// is defined, the FSM parks in TRAP and sets a sticky flag. When it is not
// defined, an illegal opcode retires as a NOP.
module mcu_fsm #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_code,
    input  logic               rt_b0,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               MemRd,
    output logic               MemWr,
    output logic               IorD,
    output logic               IRWr,
    output logic               PCWr,
    output logic               PCWrCond,
    output logic [1:0]         PCSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWr,
    output logic [2:0]         br_type,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic               illegal_op
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, RWB, IEXEC, IWB, BRANCH, JUMP
`ifdef MCU_FSM_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t           stateReg, stateNext;
    logic [5:0]       opQReg;
    logic [CNT_W-1:0] cntReg;
    logic [1:0]       aluOpLo;

    // State register plus the opcode latched during DECODE for later phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            opQReg   <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == DECODE) begin
                opQReg <= op_code;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntReg <= '0;
        end else if (instr_done) begin
            cntReg <= cntReg + CNT_W'(1);
        end
    end

`ifdef MCU_FSM_TRAP_EN
    logic illegalReg;

    // Sticky flag set when DECODE routes an unknown opcode into TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegalReg <= 1'b0;
        end else if (stateReg == DECODE && stateNext == TRAP) begin
            illegalReg <= 1'b1;
        end
    end
    assign illegal_op = illegalReg;
`else
    assign illegal_op = 1'b0;
`endif

    // Next state and Moore outputs. Only the FETCH IR/PC writes and the
    // retire pulses on ack depend on mem_ack.
    always_comb begin
        stateNext  = stateReg;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        IorD       = 1'b0;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        PCWrCond   = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        aluOpLo    = 2'b00;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWr      = 1'b0;
        br_type    = 3'b000;
        instr_done = 1'b0;
        case (stateReg)
            IDLE:   stateNext = FETCH;
            FETCH: begin
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ack) begin
                    IRWr      = 1'b1;
                    PCWr      = 1'b1;
                    stateNext = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op_code)
                    OP_LW, OP_SW:                              stateNext = MEMADR;
                    OP_RTYPE:                                  stateNext = EXEC;
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: stateNext = BRANCH;
                    OP_J:                                      stateNext = JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI:                  stateNext = IEXEC;
                    default: begin
`ifdef MCU_FSM_TRAP_EN
                        stateNext  = TRAP;
`else
                        instr_done = 1'b1;
                        stateNext  = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                stateNext = (opQReg == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
                if (mem_ack) begin
                    stateNext = MEMWB;
                end
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWr      = 1'b1;
                instr_done = 1'b1;
                stateNext  = FETCH;
            end
            MEMWR: begin
                MemWr = 1'b1;
                IorD  = 1'b1;
                if (mem_ack) begin
                    instr_done = 1'b1;
                    stateNext  = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                aluOpLo   = 2'b10;
                stateNext = RWB;
            end
            RWB: begin
                RegDst     = 1'b1;
                RegWr      = 1'b1;
                instr_done = 1'b1;
                stateNext  = FETCH;
            end
            IEXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                aluOpLo   = 2'b11;
                stateNext = IWB;
            end
            IWB: begin
                RegWr      = 1'b1;
                instr_done = 1'b1;
                stateNext  = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                aluOpLo    = 2'b01;
                PCWrCond   = 1'b1;
                PCSrc      = 2'b01;
                instr_done = 1'b1;
                stateNext  = FETCH;
                case (opQReg)
                    OP_BNE:    br_type = 3'b001;
                    OP_BLEZ:   br_type = 3'b010;
                    OP_BGTZ:   br_type = 3'b011;
                    OP_REGIMM: br_type = rt_b0 ? 3'b101 : 3'b100;
                    default:   br_type = 3'b000;
                endcase
            end
            JUMP: begin
                PCWr       = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
                stateNext  = FETCH;
            end
`ifdef MCU_FSM_TRAP_EN
            TRAP:   stateNext = TRAP;
`endif
            default: stateNext = IDLE;
        endcase
    end

    assign mem_req   = MemRd | MemWr;
    assign instr_cnt = cntReg;

    // ALUOp bits above the two meaningful ones are always zero.
    assign ALUOp[1:0] = aluOpLo;
    for (genvar gi = 2; gi < ALUOP_W; gi++) begin : gAluOpHi
        assign ALUOp[gi] = 1'b0;
    end

endmodule

// File: tb/tb_mcu_fsm.sv
// tb_mcu_fsm: checks mcu_fsm against an instruction-level model. The model
// keeps an instruction as a plan of cycle kinds, and some of those kinds wait
// for mem_ack.
`timescale 1ns/1ps
module tb_mcu_fsm;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 4;
`ifdef MCU_FSM_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] op_code = '0;
    logic rt_b0 = 1'b0;
    logic mem_ack = 1'b0;
    logic mem_req, MemRd, MemWr, IorD, IRWr, PCWr, PCWrCond, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic RegDst, MemtoReg, RegWr, instr_done, illegal_op;
    logic [2:0] br_type;
    logic [CNT_W-1:0] instr_cnt;

    always #5 clk = ~clk;

    mcu_fsm #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .rt_b0(rt_b0), .mem_ack(mem_ack),
        .mem_req(mem_req), .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD), .IRWr(IRWr),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWr(RegWr), .br_type(br_type), .instr_done(instr_done),
        .instr_cnt(instr_cnt), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic memReq, memRd, memWr, iorD, irWr, pcWr, pcWrCond;
        logic [1:0] pcSrc;
        logic aluSrcA;
        logic [1:0] aluSrcB;
        logic [ALUOP_W-1:0] aluOp;
        logic regDst, memtoReg, regWr;
        logic [2:0] brType;
        logic done, ill;
    } ctl_t;

    typedef enum int {K_IDLE, K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB, K_MEMWR,
                      K_EXEC, K_RWB, K_IEXEC, K_IWB, K_BRANCH, K_JUMP, K_TRAP} kind_t;

    ctl_t dutCtl;
    assign dutCtl = {mem_req, MemRd, MemWr, IorD, IRWr, PCWr, PCWrCond, PCSrc, ALUSrcA,
                     ALUSrcB, ALUOp, RegDst, MemtoReg, RegWr, br_type, instr_done, illegal_op};

    int vectors = 0;
    int miscompares = 0;

    // Model state: phase 0 idle, 1 fetch, 2 decode, 3 body step mIdx, 4 trap.
    int mPhase = 0;
    int mIdx = 0;
    logic [5:0] mOp = '0;
    logic [CNT_W-1:0] mCnt = '0;
    logic mIll = 1'b0;

    function automatic int planLen(input logic [5:0] op);
        case (op)
            6'b100011: return 3;
            6'b101011: return 2;
            6'b000000: return 2;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110: return 2;
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: return 1;
            6'b000010: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic kind_t planKind(input logic [5:0] op, input int idx);
        if (op == 6'b100011) return (idx == 0) ? K_MEMADR : (idx == 1) ? K_MEMRD : K_MEMWB;
        if (op == 6'b101011) return (idx == 0) ? K_MEMADR : K_MEMWR;
        if (op == 6'b000000) return (idx == 0) ? K_EXEC : K_RWB;
        if (op == 6'b000010) return K_JUMP;
        if (planLen(op) == 1) return K_BRANCH;
        return (idx == 0) ? K_IEXEC : K_IWB;
    endfunction

    function automatic bit isWait(input kind_t k);
        return (k == K_FETCH) || (k == K_MEMRD) || (k == K_MEMWR);
    endfunction

    function kind_t curKind();
        case (mPhase)
            0: return K_IDLE;
            1: return K_FETCH;
            2: return K_DECODE;
            3: return planKind(mOp, mIdx);
            default: return K_TRAP;
        endcase
    endfunction

    function bit retireNow();
        kind_t k;
        k = curKind();
        if (mPhase == 2) return (planLen(op_code) == 0) && !TRAP_EN;
        if (mPhase == 3) return (mIdx == planLen(mOp) - 1) && !(isWait(k) && !mem_ack);
        return 1'b0;
    endfunction

    function automatic logic [2:0] brCode(input logic [5:0] op, input logic rt);
        case (op)
            6'b000100: return 3'd0;
            6'b000101: return 3'd1;
            6'b000110: return 3'd2;
            6'b000111: return 3'd3;
            default:   return rt ? 3'd5 : 3'd4;
        endcase
    endfunction

    function ctl_t expCtl();
        ctl_t e;
        e = '0;
        case (curKind())
            K_FETCH:  begin e.memRd = 1; e.aluSrcB = 2'b01; e.irWr = mem_ack; e.pcWr = mem_ack; end
            K_DECODE: e.aluSrcB = 2'b11;
            K_MEMADR: begin e.aluSrcA = 1; e.aluSrcB = 2'b10; end
            K_MEMRD:  begin e.memRd = 1; e.iorD = 1; end
            K_MEMWB:  begin e.memtoReg = 1; e.regWr = 1; end
            K_MEMWR:  begin e.memWr = 1; e.iorD = 1; end
            K_EXEC:   begin e.aluSrcA = 1; e.aluOp = ALUOP_W'(2); end
            K_RWB:    begin e.regDst = 1; e.regWr = 1; end
            K_IEXEC:  begin e.aluSrcA = 1; e.aluSrcB = 2'b10; e.aluOp = ALUOP_W'(3); end
            K_IWB:    e.regWr = 1;
            K_BRANCH: begin
                e.aluSrcA = 1; e.aluOp = ALUOP_W'(1); e.pcWrCond = 1; e.pcSrc = 2'b01;
                e.brType = brCode(mOp, rt_b0);
            end
            K_JUMP:   begin e.pcWr = 1; e.pcSrc = 2'b10; end
            default:  ;
        endcase
        e.memReq = e.memRd | e.memWr;
        e.done   = retireNow();
        e.ill    = mIll;
        return e;
    endfunction

    // Model advance: one step of the instruction plan per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase <= 0; mIdx <= 0; mOp <= '0; mCnt <= '0; mIll <= 1'b0;
        end else begin
            if (retireNow()) mCnt <= mCnt + CNT_W'(1);
            case (mPhase)
                0: mPhase <= 1;
                1: if (mem_ack) mPhase <= 2;
                2: begin
                    mOp  <= op_code;
                    mIdx <= 0;
                    if (planLen(op_code) != 0) mPhase <= 3;
                    else if (TRAP_EN) begin mPhase <= 4; mIll <= 1'b1; end
                    else mPhase <= 1;
                end
                3: if (!(isWait(curKind()) && !mem_ack)) begin
                    if (mIdx == planLen(mOp) - 1) mPhase <= 1;
                    else mIdx <= mIdx + 1;
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of all controls and the counter against the model.
    always @(negedge clk) begin
        ctl_t e;
        e = expCtl();
        vectors++;
        if (dutCtl !== e || instr_cnt !== mCnt) begin
            miscompares++;
            $display("FAIL cycle kind=%0d: ctl got %h required %h, cnt got %0d required %0d",
                     curKind(), dutCtl, e, instr_cnt, mCnt);
        end
    end

    int waitCnt = 0;
    int irwrCnt = 0;
    bit sawDone = 0;
    ctl_t lastCtl;

    task automatic checkEq(input string name, input logic [63:0] got, input logic [63:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // One clock of stimulus; mem_ack is withheld for lowF/lowM cycles in wait kinds.
    task automatic stepAuto(input logic [5:0] op, input logic rt, input int lowF, input int lowM);
        kind_t k;
        k = curKind();
        if (k == K_FETCH) mem_ack = (waitCnt >= lowF);
        else if (isWait(k)) mem_ack = (waitCnt >= lowM);
        else mem_ack = 1'($urandom_range(0, 1));
        op_code = (k == K_FETCH) ? 6'($urandom) : op;
        rt_b0 = rt;
        #1;
        if (IRWr) irwrCnt++;
        lastCtl = dutCtl;
        sawDone = instr_done;
        @(posedge clk); #1;
        if (curKind() == k) waitCnt++;
        else waitCnt = 0;
    endtask

    task automatic runInstr(input logic [5:0] op, input logic rt, input int lowF, input int lowM,
                            output int cycles);
        cycles = 0; irwrCnt = 0; sawDone = 0;
        while (!sawDone && mPhase != 4 && cycles < 200) begin
            stepAuto(op, rt, lowF, lowM);
            cycles++;
        end
        if (!sawDone && mPhase != 4) begin
            vectors++; miscompares++;
            $display("FAIL retire_timeout: op %b got no retire in %0d cycles", op, cycles);
        end
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge clk);
        #1;
        checkEq("reset_ctl", dutCtl, 0);
        checkEq("reset_cnt", instr_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        waitCnt = 0;
    endtask

    task automatic doReset();
        rst_n = 1'b0; mem_ack = 1'b0; op_code = '0; rt_b0 = 1'b0;
        releaseReset();
    endtask

    logic [5:0] legalOps [16] = '{6'b000000, 6'b000001, 6'b000010, 6'b000100, 6'b000101,
                                  6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001010,
                                  6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b100011,
                                  6'b101011};
    logic [5:0] badOps [4] = '{6'b111111, 6'b000011, 6'b001111, 6'b010000};

    initial begin
        int cyc;
        int guard;
        logic [5:0] op;
        doReset();

        // R-type with immediate acks: 4 cycles, one retire.
        runInstr(6'b000000, 1'b0, 0, 0, cyc);
        checkEq("rtype_cycles", cyc, 4);
        checkEq("rtype_regdst", lastCtl.regDst, 1);
        checkEq("rtype_cnt", instr_cnt, 1);

        // LW with 3 idle ack cycles in FETCH and MEMRD: 11 cycles.
        doReset();
        runInstr(6'b100011, 1'b0, 3, 3, cyc);
        checkEq("lw_cycles", cyc, 11);
        checkEq("lw_irwr_pulses", irwrCnt, 1);
        checkEq("lw_memwb_memtoreg", lastCtl.memtoReg, 1);
        checkEq("lw_memwb_regwr", lastCtl.regWr, 1);

        // SW then BNE.
        doReset();
        runInstr(6'b101011, 1'b0, 1, 2, cyc);
        checkEq("sw_cycles", cyc, 7);
        checkEq("sw_memwr_at_ack", lastCtl.memWr, 1);
        runInstr(6'b000101, 1'b0, 0, 0, cyc);
        checkEq("bne_pcwrcond", lastCtl.pcWrCond, 1);
        checkEq("bne_br_type", lastCtl.brType, 1);
        checkEq("bne_aluop", lastCtl.aluOp, 1);

        // ORI then J.
        doReset();
        runInstr(6'b001101, 1'b0, 0, 0, cyc);
        checkEq("ori_cycles", cyc, 4);
        runInstr(6'b000010, 1'b0, 0, 0, cyc);
        checkEq("j_pcwr", lastCtl.pcWr, 1);
        checkEq("j_pcsrc", lastCtl.pcSrc, 2);
        checkEq("ori_j_cnt", instr_cnt, 2);

        // Counter wrap with CNT_W=4.
        doReset();
        for (int i = 1; i <= 16; i++) begin
            runInstr(6'b000010, 1'b0, 0, 0, cyc);
            if (i == 15) checkEq("cnt_at_15", instr_cnt, 15);
            if (i == 16) checkEq("cnt_wrap", instr_cnt, 0);
        end

        // Illegal opcode 111111.
        doReset();
        runInstr(6'b111111, 1'b0, 0, 0, cyc);
        if (TRAP_EN) begin
            repeat (4) stepAuto(6'b111111, 1'b0, 0, 0);
            checkEq("trap_flag", illegal_op, 1);
            checkEq("trap_cnt", instr_cnt, 0);
        end else begin
            checkEq("nop_cycles", cyc, 2);
            checkEq("nop_cnt", instr_cnt, 1);
            checkEq("nop_flag", illegal_op, 0);
        end

        // Reset in the middle of a MEMRD wait.
        doReset();
        runInstr(6'b000000, 1'b0, 0, 0, cyc);
        guard = 0;
        while (!(curKind() == K_MEMRD && waitCnt == 2) && guard < 50) begin
            stepAuto(6'b100011, 1'b0, 0, 100);
            guard++;
        end
        if (guard >= 50) begin
            vectors++; miscompares++;
            $display("FAIL memrd_reach_timeout: got %0d cycles required < 50", guard);
        end
        #1 rst_n = 1'b0;
        #1;
        checkEq("abort_ctl", dutCtl, 0);
        checkEq("abort_cnt", instr_cnt, 0);
        releaseReset();
        runInstr(6'b000000, 1'b0, 0, 0, cyc);
        checkEq("post_abort_cycles", cyc, 4);

        // Randomized instruction stream.
        doReset();
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 9) == 0) op = badOps[$urandom_range(0, 3)];
            else op = legalOps[$urandom_range(0, 15)];
            runInstr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), cyc);
            if (mPhase == 4) begin
                repeat (3) stepAuto(op, 1'b0, 0, 0);
                checkEq("rand_trap_flag", illegal_op, 1);
                doReset();
            end else if ($urandom_range(0, 99) == 0) begin
                doReset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
